// File: rtl/ahb_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ahb_timer_ctrl
// Description : AHB-Lite slave that runs a BITS-wide counter as a timer with
//               a prescaler, terminal-count compare, one-shot or periodic
//               mode, a sticky DONE flag and an interrupt. The counter value
//               is driven onto the GPIO pins when output enable is set.
// Revision    : 1.0  initial release
// ============================================================================
module ahb_timer_ctrl #(
  parameter int BITS     = 16,
  parameter int PRE_BITS = 8
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSEL,
  input  logic                HREADY,
  input  logic                HWRITE,
  input  logic [31:0]         HADDR,
  input  logic [31:0]         HWDATA,
  input  logic [2:0]          HSIZE,
  input  logic [1:0]          HTRANS,
  output logic                HREADYOUT,
  output logic [31:0]         HRDATA,
  output logic [BITS-1:0]     gpio_out,
  output logic [BITS-1:0]     gpio_oeb,
  output logic                irq
);

  localparam logic [15:0]         c_OFF_CTRL   = 16'h0000;
  localparam logic [15:0]         c_OFF_LOAD   = 16'h0004;
  localparam logic [15:0]         c_OFF_PRE    = 16'h0008;
  localparam logic [15:0]         c_OFF_COUNT  = 16'h000C;
  localparam logic [15:0]         c_OFF_STATUS = 16'h0010;
  localparam logic [15:0]         c_OFF_IRQEN  = 16'h0014;
  localparam logic [BITS-1:0]     c_ONE_CNT    = BITS'(1);
  localparam logic [PRE_BITS-1:0] c_ONE_PRE    = PRE_BITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Registered address phase
  logic                valid_q;
  logic                write_q;
  logic [15:0]         addr_q;

  // Timer state
  state_e              state_q,  state_d;
  logic                en_q,     en_d;
  logic                per_q,    per_d;
  logic                oe_q,     oe_d;
  logic [BITS-1:0]     load_q,   load_d;
  logic [PRE_BITS-1:0] pre_q,    pre_d;
  logic [BITS-1:0]     count_q,  count_d;
  logic [PRE_BITS-1:0] psc_q,    psc_d;
  logic                done_q,   done_d;
  logic                irqen_q,  irqen_d;

  logic w_wr;
  logic w_wr_ctrl, w_wr_load, w_wr_pre, w_wr_count, w_wr_status, w_wr_irqen;
  logic w_tick;
  logic w_done_set;

  // Upper address bits, transfer size and HTRANS[0] carry no meaning here
  logic unused_ok;
  assign unused_ok = ^{HSIZE, HADDR[31:16], HTRANS[0], HWDATA};

  assign w_wr        = valid_q & write_q;
  assign w_wr_ctrl   = w_wr && (addr_q == c_OFF_CTRL);
  assign w_wr_load   = w_wr && (addr_q == c_OFF_LOAD);
  assign w_wr_pre    = w_wr && (addr_q == c_OFF_PRE);
  assign w_wr_count  = w_wr && (addr_q == c_OFF_COUNT);
  assign w_wr_status = w_wr && (addr_q == c_OFF_STATUS);
  assign w_wr_irqen  = w_wr && (addr_q == c_OFF_IRQEN);

  assign w_tick = (state_q == ST_RUN) && (psc_q == pre_q);

  // Capture the address phase whenever the bus is ready
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= 16'h0000;
    end else if (HREADY) begin
      valid_q <= HSEL & HTRANS[1];
      write_q <= HWRITE;
      addr_q  <= HADDR[15:0];
    end
  end

  // Timer state and register file
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      per_q   <= 1'b0;
      oe_q    <= 1'b0;
      load_q  <= '0;
      pre_q   <= '0;
      count_q <= '0;
      psc_q   <= '0;
      done_q  <= 1'b0;
      irqen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      per_q   <= per_d;
      oe_q    <= oe_d;
      load_q  <= load_d;
      pre_q   <= pre_d;
      count_q <= count_d;
      psc_q   <= psc_d;
      done_q  <= done_d;
      irqen_q <= irqen_d;
    end
  end

  // Next state: hardware timing first, bus writes override where they win
  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    per_d      = per_q;
    oe_d       = oe_q;
    load_d     = load_q;
    pre_d      = pre_q;
    count_d    = count_q;
    psc_d      = psc_q;
    done_d     = done_q;
    irqen_d    = irqen_q;
    w_done_set = 1'b0;

    if (state_q == ST_RUN) begin
      psc_d = w_tick ? '0 : psc_q + c_ONE_PRE;
      if (w_tick) begin
        if (count_q != load_q) begin
          count_d = count_q + c_ONE_CNT;
        end else begin
          w_done_set = 1'b1;
          if (per_q) begin
            count_d = '0;
          end else begin
            state_d = ST_HALT;
            en_d    = 1'b0;
          end
        end
      end
    end

    // A CTRL write starts/restarts or stops the timer, overriding the tick
    if (w_wr_ctrl) begin
      en_d  = HWDATA[0];
      per_d = HWDATA[1];
      oe_d  = HWDATA[2];
      psc_d = '0;
      if (HWDATA[0]) begin
        state_d = ST_RUN;
        count_d = '0;
      end else begin
        state_d = ST_IDLE;
        count_d = count_q;
      end
    end

    // A COUNT write replaces the whole tick, including any terminal action
    if (w_wr_count) begin
      count_d    = HWDATA[BITS-1:0];
      psc_d      = '0;
      state_d    = state_q;
      en_d       = en_q;
      w_done_set = 1'b0;
    end

    if (w_wr_load)  load_d  = HWDATA[BITS-1:0];
    if (w_wr_pre)   pre_d   = HWDATA[PRE_BITS-1:0];
    if (w_wr_irqen) irqen_d = HWDATA[0];

    // Hardware set is applied last so it wins over a same-cycle clear
    if (w_wr_status && HWDATA[0]) done_d = 1'b0;
    if (w_done_set)               done_d = 1'b1;
  end

  // Read mux driven from the registered address
  always_comb begin
    HRDATA = 32'h0000_0000;
    case (addr_q)
      c_OFF_CTRL:   HRDATA = {29'd0, oe_q, per_q, en_q};
      c_OFF_LOAD:   HRDATA = 32'(load_q);
      c_OFF_PRE:    HRDATA = 32'(pre_q);
      c_OFF_COUNT:  HRDATA = 32'(count_q);
      c_OFF_STATUS: HRDATA = {30'd0, (state_q == ST_RUN), done_q};
      c_OFF_IRQEN:  HRDATA = {31'd0, irqen_q};
      default:      HRDATA = 32'hDEAD_BEEF;
    endcase
  end

  assign HREADYOUT = 1'b1;
  assign gpio_out  = count_q;
  assign gpio_oeb  = {BITS{~oe_q}};
  assign irq       = done_q & irqen_q;

endmodule
`default_nettype wire

// File: doc/ahb_timer_ctrl.md
# ahb_timer_ctrl

AHB-Lite slave that sequences a free-standing BITS-wide counter as a programmable timer: prescaled ticks, terminal-count compare, one-shot or periodic operation, a sticky done flag, and an interrupt. It sits on the user-area AHB-Lite bus beside the GPIO blocks. The counter value drives the GPIO pins under software output-enable control.

## Interface
- BITS, 16: counter, LOAD and gpio width (2..32)
- PRE_BITS, 8: prescaler width (1..16)

- HCLK  in  1  bus and core clock
- HRESETn  in  1  reset, asynchronous, active-low
- HSEL, HREADY, HWRITE  in  1 each  AHB-Lite select / ready-in / write
- HADDR  in  32  address; only HADDR[15:0] is decoded
- HWDATA  in  32  write data (data phase)
- HSIZE  in  3  ignored; all accesses are treated as 32-bit
- HTRANS  in  2  transfer type; a transfer is valid when HTRANS[1]=1
- HREADYOUT  out  1  constant 1 (zero wait states)
- HRDATA  out  32  read data
- gpio_out  out  BITS  current COUNT
- gpio_oeb  out  BITS  {BITS{~CTRL.OE}}
- irq  out  1  STATUS.DONE & IRQEN

## Operation
- Address phase: HSEL, HADDR, HWRITE and HTRANS are registered when HREADY=1. The access completes in the next cycle, using HWDATA from that cycle.
- Register map (offsets; unused bits read 0):
  - 0x00 CTRL, RW: bit0 EN, bit1 PERIODIC, bit2 OE.
  - 0x04 LOAD, RW: terminal count, BITS wide.
  - 0x08 PRESCALE, RW: PRE_BITS wide; one tick every PRESCALE+1 cycles.
  - 0x0C COUNT, RW: a write loads the counter.
  - 0x10 STATUS: bit0 DONE is write-1-to-clear; bit1 RUNNING is read-only.
  - 0x14 IRQEN, RW: bit0.
  - Any other offset reads 32'hDEADBEEF; writes to it are ignored.
- FSM states: IDLE, RUN, HALT.
  - IDLE -> RUN: a CTRL write with EN=1. COUNT and the prescaler are cleared to 0.
  - RUN: the prescaler increments every cycle. When it equals PRESCALE it wraps to 0 and produces a tick.
  - On a tick with COUNT != LOAD, COUNT increments by 1.
  - On a tick with COUNT == LOAD, DONE is set. If PERIODIC=1, COUNT becomes 0 and the FSM stays in RUN. If PERIODIC=0, the FSM goes to HALT, COUNT is held and hardware clears CTRL.EN.
  - RUN -> IDLE: a CTRL write with EN=0. COUNT is held and the prescaler is cleared.
  - HALT -> RUN: a CTRL write with EN=1 (restart from 0). HALT -> IDLE: a CTRL write with EN=0.
  - A CTRL write with EN=1 while in RUN restarts the timer: COUNT and the prescaler go to 0.
- STATUS.RUNNING = (state == RUN).
- Width rules: COUNT increments modulo 2^BITS. If LOAD is larger than COUNT, the counter reaches LOAD without wrapping. LOAD=0 in periodic mode sets DONE on every tick.
- Priorities (same cycle):
  - A bus write to COUNT beats a tick. COUNT takes the written value and the prescaler clears.
  - A hardware DONE set beats a software W1C.
  - A CTRL write beats hardware clearing of EN.
- Reset values: all registers 0, state IDLE, DONE 0. Outputs at reset: HRDATA = 0 (decode of offset 0x00), HREADYOUT 1, gpio_out 0, gpio_oeb all 1, irq 0.
- An asynchronous reset mid-count returns everything to the reset values immediately.

## Timing
- Write: the address phase is in cycle N and the data phase in cycle N+1. The register updates at the end of N+1 and the new value is visible from N+2. A state change is also visible from N+2.
- Read: HRDATA is combinational from the registered address and valid throughout the data phase. Back-to-back transfers are supported.
- First tick: PRESCALE+1 cycles after entering RUN. Consecutive ticks are PRESCALE+1 cycles apart.
- DONE and irq assert one cycle after the terminal tick edge, with no extra register stage after DONE.
- gpio_out follows COUNT with zero added latency.

## Test plan
- Reset: after HRESETn is released, every register reads 0, gpio_oeb=16'hFFFF, irq=0, and offset 0x20 reads 32'hDEADBEEF.
- One-shot: write LOAD=3, PRESCALE=1, CTRL=0x1. Required: COUNT steps 0,1,2,3 every 2 cycles, DONE=1, state HALT, CTRL reads 0x0, COUNT holds at 3.
- Periodic with irq: write LOAD=2, PRESCALE=0, IRQEN=1, CTRL=0x3. Required: COUNT sequence 0,1,2,0,1,2 and irq rises one cycle after the first wrap. After W1C of STATUS=0x1, irq falls and reasserts at the next wrap.
- Collision: a COUNT write of 0x00FF lands on the same edge as a tick, and a W1C lands on a DONE set. Required: COUNT=0x00FF then 0x0100 after PRESCALE+1 cycles; DONE remains 1.
- Stop/restart and OE: CTRL=0x0 mid-run leaves COUNT frozen and RUNNING=0. CTRL=0x5 restarts from 0 and drives gpio_oeb=0.
- Async reset asserted mid-RUN: all outputs return to their reset values within the same cycle.
